axil_arb_2to1: RTL
==================

Name: axil_arb_2to1

Overview:
- Two-master to one-slave AXI4-Lite arbiter.
- Lets a host-side control master and an on-chip autonomous poller (stats sampler) share the single AXI-Lite register slave of the traffic generator/checker.
- Write and read paths are arbitrated independently, each with round-robin priority.
- At most one outstanding transaction per path.

Parameters:
- ADDR_W, 7, AXI-Lite address width on all three ports.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  single clock for all ports.
- rst  in  1  synchronous, active-high reset.
- sN_axil_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  master N write-address channel (N = 0, 1).
- sN_axil_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_W/DATA_W/8/1/1  master N write-data channel.
- sN_axil_bresp/bvalid/bready  out/out/in  2/1/1  master N write-response channel.
- sN_axil_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  master N read-address channel.
- sN_axil_rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  master N read-data channel.
- m_axil_*  mirror set (aw/w/b/ar/r) with opposite directions  towards the shared slave.
- wr_grant  out  1  index of the master currently or last granted the write path.
- rd_grant  out  1  index of the master currently or last granted the read path.

Behaviour:

Reset:
- Write FSM = WIDLE, read FSM = RIDLE.
- wr_grant = 1 and rd_grant = 1, so master 0 wins the first contention.
- All ready/valid outputs = 0; bresp/rresp/rdata forwarded, value don't-care while invalid.

Write FSM: WIDLE -> WADDR -> WDATA -> WRESP -> WIDLE.
- WIDLE:
  - Requests are sN_axil_awvalid. None: stay.
  - One requester: register it into wr_grant.
  - Both: grant ~wr_grant (round-robin).
  - Go to WADDR next cycle. No handshake occurs in WIDLE (1-cycle arbitration latency).
- WADDR:
  - m_axil_awaddr/awvalid driven from the granted master; s_grant awready = m_axil_awready; the other master's awready = 0.
  - On m_axil_awvalid & m_axil_awready -> WDATA.
- WDATA:
  - W channel forwarded likewise.
  - On m_axil_wvalid & m_axil_wready -> WRESP.
  - W beats presented by the granted master before WDATA are held by that master (its wready = 0), never dropped.
- WRESP:
  - m_axil_bresp/bvalid routed to the granted master; m_axil_bready = granted bready; the other master's bvalid = 0.
  - On B handshake -> WIDLE.
  - Next arbitration can start the cycle after the B handshake.

Read FSM: RIDLE -> RADDR -> RDATA -> RIDLE.
- Same rules as the write FSM, using arvalid for requests and rd_grant for the grant.
- The R handshake returns the FSM to RIDLE.

Path independence:
- Read and write paths never block each other.
- Master 0 may own the write path while master 1 owns the read path.

Non-granted masters:
- All ready and valid outputs towards a non-granted master are 0.
- Its pending awvalid/arvalid stays asserted per AXI rules and is served at the next arbitration.

Fairness:
- Under continuous dual request, grants strictly alternate 0,1,0,1.
- Neither master waits more than one foreign transaction.

Sustained rate and ordering:
- Max sustained rate per path: one transaction per 4 cycles (write) or 3 cycles (read) with a zero-wait slave.
- No address decode: the full address passes unchanged; responses are routed purely by grant.

Error handling:
- bresp/rresp pass through unmodified.
- The arbiter never generates its own response.

Reset mid-transaction:
- rst takes effect on the next clock edge regardless of FSM state, returning to reset values.
- The slave is reset on the same rst (same domain), so no orphaned responses are tracked.

Test Plan:
- Single master 0 write, addr 0x00 data 0x1, zero-wait slave -> m_axil_awaddr=0x00, wdata=0x1 forwarded; s0 bvalid after 4 cycles; wr_grant=0; s1 sees no ready/valid.
- Both masters assert arvalid in the same cycle after reset (addr 0x14 and 0x18) -> master 0 served first (rdata = freq value); master 1 served next; rd_grant sequence 0 then 1; each master gets only its own rdata.
- Both masters issue 8 back-to-back writes continuously -> slave sees strictly alternating 0,1,0,... origin; all 16 B responses are routed to the correct master; no lost beat.
- Concurrent write from master 1 (addr 0x04) and read from master 0 (addr 0x48) -> both complete in overlapping cycles; wr_grant=1, rd_grant=0.
- Slave stalls awready 5 cycles, wready 3 cycles, bvalid 2 cycles; granted master stalls bready 4 cycles -> all stalls propagate and the FSM holds state; the other master's later request waits until WIDLE.
- rst asserted while the write FSM is in WDATA -> next cycle all valids/readies = 0, wr_grant=1, FSM=WIDLE; a new master 0 request completes normally.

Source files
------------

// File: rtl/axil_arb_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter. The write and read paths each run their
// own round-robin FSM and allow one outstanding transaction per path.
module axil_arb_2to1 #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   s0_axil_awaddr,
    input  logic                s0_axil_awvalid,
    output logic                s0_axil_awready,
    input  logic [DATA_W-1:0]   s0_axil_wdata,
    input  logic [DATA_W/8-1:0] s0_axil_wstrb,
    input  logic                s0_axil_wvalid,
    output logic                s0_axil_wready,
    output logic [1:0]          s0_axil_bresp,
    output logic                s0_axil_bvalid,
    input  logic                s0_axil_bready,
    input  logic [ADDR_W-1:0]   s0_axil_araddr,
    input  logic                s0_axil_arvalid,
    output logic                s0_axil_arready,
    output logic [DATA_W-1:0]   s0_axil_rdata,
    output logic [1:0]          s0_axil_rresp,
    output logic                s0_axil_rvalid,
    input  logic                s0_axil_rready,

    input  logic [ADDR_W-1:0]   s1_axil_awaddr,
    input  logic                s1_axil_awvalid,
    output logic                s1_axil_awready,
    input  logic [DATA_W-1:0]   s1_axil_wdata,
    input  logic [DATA_W/8-1:0] s1_axil_wstrb,
    input  logic                s1_axil_wvalid,
    output logic                s1_axil_wready,
    output logic [1:0]          s1_axil_bresp,
    output logic                s1_axil_bvalid,
    input  logic                s1_axil_bready,
    input  logic [ADDR_W-1:0]   s1_axil_araddr,
    input  logic                s1_axil_arvalid,
    output logic                s1_axil_arready,
    output logic [DATA_W-1:0]   s1_axil_rdata,
    output logic [1:0]          s1_axil_rresp,
    output logic                s1_axil_rvalid,
    input  logic                s1_axil_rready,

    output logic [ADDR_W-1:0]   m_axil_awaddr,
    output logic                m_axil_awvalid,
    input  logic                m_axil_awready,
    output logic [DATA_W-1:0]   m_axil_wdata,
    output logic [DATA_W/8-1:0] m_axil_wstrb,
    output logic                m_axil_wvalid,
    input  logic                m_axil_wready,
    input  logic [1:0]          m_axil_bresp,
    input  logic                m_axil_bvalid,
    output logic                m_axil_bready,
    output logic [ADDR_W-1:0]   m_axil_araddr,
    output logic                m_axil_arvalid,
    input  logic                m_axil_arready,
    input  logic [DATA_W-1:0]   m_axil_rdata,
    input  logic [1:0]          m_axil_rresp,
    input  logic                m_axil_rvalid,
    output logic                m_axil_rready,

    output logic                wr_grant,
    output logic                rd_grant
);

    typedef enum logic [1:0] {WIDLE, WADDR, WDATA, WRESP} wr_state_e;
    typedef enum logic [1:0] {RIDLE, RADDR, RDATA} rd_state_e;

    wr_state_e wr_state_q;
    rd_state_e rd_state_q;
    logic      wr_grant_q;
    logic      rd_grant_q;

    logic wr_addr_ph, wr_data_ph, wr_resp_ph;
    logic rd_addr_ph, rd_data_ph;

    assign wr_addr_ph = (wr_state_q == WADDR);
    assign wr_data_ph = (wr_state_q == WDATA);
    assign wr_resp_ph = (wr_state_q == WRESP);
    assign rd_addr_ph = (rd_state_q == RADDR);
    assign rd_data_ph = (rd_state_q == RDATA);

    assign wr_grant = wr_grant_q;
    assign rd_grant = rd_grant_q;

    // Write path: payloads follow the grant, handshake signals are gated by the phase
    // so that an early W beat from the granted master is held until WDATA.
    assign m_axil_awaddr   = wr_grant_q ? s1_axil_awaddr : s0_axil_awaddr;
    assign m_axil_awvalid  = wr_addr_ph & (wr_grant_q ? s1_axil_awvalid : s0_axil_awvalid);
    assign s0_axil_awready = wr_addr_ph & ~wr_grant_q & m_axil_awready;
    assign s1_axil_awready = wr_addr_ph &  wr_grant_q & m_axil_awready;

    assign m_axil_wdata    = wr_grant_q ? s1_axil_wdata : s0_axil_wdata;
    assign m_axil_wstrb    = wr_grant_q ? s1_axil_wstrb : s0_axil_wstrb;
    assign m_axil_wvalid   = wr_data_ph & (wr_grant_q ? s1_axil_wvalid : s0_axil_wvalid);
    assign s0_axil_wready  = wr_data_ph & ~wr_grant_q & m_axil_wready;
    assign s1_axil_wready  = wr_data_ph &  wr_grant_q & m_axil_wready;

    assign s0_axil_bresp   = m_axil_bresp;
    assign s1_axil_bresp   = m_axil_bresp;
    assign s0_axil_bvalid  = wr_resp_ph & ~wr_grant_q & m_axil_bvalid;
    assign s1_axil_bvalid  = wr_resp_ph &  wr_grant_q & m_axil_bvalid;
    assign m_axil_bready   = wr_resp_ph & (wr_grant_q ? s1_axil_bready : s0_axil_bready);

    assign m_axil_araddr   = rd_grant_q ? s1_axil_araddr : s0_axil_araddr;
    assign m_axil_arvalid  = rd_addr_ph & (rd_grant_q ? s1_axil_arvalid : s0_axil_arvalid);
    assign s0_axil_arready = rd_addr_ph & ~rd_grant_q & m_axil_arready;
    assign s1_axil_arready = rd_addr_ph &  rd_grant_q & m_axil_arready;

    assign s0_axil_rdata   = m_axil_rdata;
    assign s1_axil_rdata   = m_axil_rdata;
    assign s0_axil_rresp   = m_axil_rresp;
    assign s1_axil_rresp   = m_axil_rresp;
    assign s0_axil_rvalid  = rd_data_ph & ~rd_grant_q & m_axil_rvalid;
    assign s1_axil_rvalid  = rd_data_ph &  rd_grant_q & m_axil_rvalid;
    assign m_axil_rready   = rd_data_ph & (rd_grant_q ? s1_axil_rready : s0_axil_rready);

    // Arbitration in WIDLE: a lone requester takes the grant, contention flips it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= WIDLE;
            wr_grant_q <= 1'b1;
        end else begin
            case (wr_state_q)
                WIDLE: begin
                    if (s0_axil_awvalid | s1_axil_awvalid) begin
                        wr_grant_q <= (s0_axil_awvalid & s1_axil_awvalid) ? ~wr_grant_q
                                                                          : s1_axil_awvalid;
                        wr_state_q <= WADDR;
                    end
                end
                WADDR: if (m_axil_awvalid & m_axil_awready) wr_state_q <= WDATA;
                WDATA: if (m_axil_wvalid & m_axil_wready)   wr_state_q <= WRESP;
                WRESP: if (m_axil_bvalid & m_axil_bready)   wr_state_q <= WIDLE;
                default: wr_state_q <= WIDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= RIDLE;
            rd_grant_q <= 1'b1;
        end else begin
            case (rd_state_q)
                RIDLE: begin
                    if (s0_axil_arvalid | s1_axil_arvalid) begin
                        rd_grant_q <= (s0_axil_arvalid & s1_axil_arvalid) ? ~rd_grant_q
                                                                          : s1_axil_arvalid;
                        rd_state_q <= RADDR;
                    end
                end
                RADDR: if (m_axil_arvalid & m_axil_arready) rd_state_q <= RDATA;
                RDATA: if (m_axil_rvalid & m_axil_rready)   rd_state_q <= RIDLE;
                default: rd_state_q <= RIDLE;
            endcase
        end
    end

endmodule
